// File: rtl/mips_muldiv_hilo.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: 32-iteration shift-add
// multiply and restoring divide, plus MTHI/MTLO single-cycle writes.
module mips_muldiv_hilo #(
    parameter bit DISP_VALS_TO_OUT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state, next_state;
    logic [4:0]         counter;
    logic               busy_d, done_d;
    logic               is_div, neg_q, neg_r, b_zero;
    logic [31:0]        m_op, a_raw;
    logic [63:0]        acc;
    logic [32:0]        add_sum, div_shift, div_diff;
    logic signed [31:0] a_s, b_s;
    logic               signed_op, sa, sb, accept_arith;

    function automatic logic [31:0] mag32(input logic signed [31:0] x, input logic en);
        return (en && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] fix32(input logic [31:0] x, input logic en);
        return en ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] fix64(input logic [63:0] x, input logic en);
        return en ? (~x + 64'd1) : x;
    endfunction

    assign a_s          = op_a;
    assign b_s          = op_b;
    assign signed_op    = ~op[0];
    assign sa           = signed_op & a_s[31];
    assign sb           = signed_op & b_s[31];
    assign accept_arith = (state == IDLE) && start && !op[2];

    // acc holds {partial product} for multiply, {remainder, quotient} for divide
    assign add_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? m_op : 32'd0)};
    assign div_shift = {acc[63:32], acc[31]};
    assign div_diff  = div_shift - {1'b0, m_op};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            counter <= (state == RUN) ? counter + 5'd1 : 5'd0;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !op[2]) next_state = RUN;
            RUN:     if (counter == 5'd31) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (next_state != IDLE);
        done_d = (state == FINISH);
    end

    always_ff @(posedge clk) begin
        if (accept_arith) begin
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            a_raw  <= op_a;
            b_zero <= (op_b == 32'd0);
            m_op   <= op[1] ? mag32(b_s, signed_op) : mag32(a_s, signed_op);
            acc    <= {32'd0, (op[1] ? mag32(a_s, signed_op) : mag32(b_s, signed_op))};
        end else if (state == RUN) begin
            if (is_div)
                acc <= div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0],  acc[30:0], 1'b1};
            else
                acc <= {add_sum, acc[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state == IDLE && start && op == OP_MTHI) begin
            hi <= op_a;
        end else if (state == IDLE && start && op == OP_MTLO) begin
            lo <= op_a;
        end else if (state == FINISH) begin
            if (is_div && b_zero) begin
                hi <= a_raw;
                lo <= 32'hFFFF_FFFF;
            end else if (is_div) begin
                hi <= fix32(acc[63:32], neg_r);
                lo <= fix32(acc[31:0], neg_q);
            end else begin
                {hi, lo} <= fix64(acc, neg_q);
            end
        end
    end

    generate
        if (DISP_VALS_TO_OUT) begin : g_disp
            always_ff @(posedge clk) begin
                if (done) $display("MULDIV : OUT: %h,%h", hi, lo);
            end
        end
    endgenerate

endmodule

// File: doc/mips_muldiv_hilo.md
Name: mips_muldiv_hilo

Overview:
Multi-cycle multiply/divide unit owning the HI and LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits directly downstream of the register file. op_a and op_b are driven from register_a_data (rs) and register_b_data (rt).
- hi and lo feed the writeback mux for MFHI/MFLO.
- The control FSM holds the CPU while busy is high.

Parameters:
DISP_VALS_TO_OUT, 0, when 1 $display "MULDIV : OUT: hi,lo" in hex on every cycle done is high.

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled on posedge only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
op_a  input  32  rs value (multiplicand / dividend / MTHI,MTLO source)
op_b  input  32  rt value (multiplier / divisor)
busy  output  1  high while an arithmetic op is in flight
done  output  1  one-cycle pulse: hi/lo hold the new arithmetic result
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE, hi=lo=0, busy=0, done=0, counter=0. An in-flight op is abandoned with no partial writes.
- States: IDLE, RUN, FINISH. busy = (state != IDLE), registered.
- IDLE + start + op in {MULT,MULTU,DIV,DIVU}:
  - latch operands; for signed ops latch absolute values plus result sign flags.
  - counter=0; next state RUN.
- IDLE + start + MTHI: hi<=op_a at that edge. No busy, no done, lo unchanged. MTLO is symmetric on lo.
- IDLE + start + op=11x: no state change.
- start while busy=1: ignored. Latched operands must not change.
- RUN: one iteration per cycle, exactly 32 cycles, counter 0..31. Next state is FINISH after counter=31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring divide; one quotient bit per cycle; 32-bit partial remainder with a 33-bit subtract.
- FINISH (1 cycle): apply sign fixup and write hi/lo at the exiting edge; state->IDLE; done<=1 for exactly one cycle.
- Latency: start edge E0 → hi/lo updated and done=1 after edge E33. busy high for cycles E0+..E33-.
- Back-to-back: start is accepted in the cycle done=1 (state IDLE then).
- hi/lo keep their old values throughout RUN/FINISH until the FINISH edge.
- Multiply result: {hi,lo} = 64-bit product.
  - MULT: signed 32x32 product; negate the 64-bit magnitude if operand signs differ.
  - MULTU: unsigned product.
- Divide result: lo = quotient, hi = remainder.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend (truncate toward zero).
  - DIVU: unsigned.
- Divisor zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=op_a (raw latched value). No sign fixup. Same latency, done still pulses.
- DIV 0x80000000 / 0xFFFFFFFF: lo=32'h80000000, hi=0. No trap.
- Reset asserted mid-RUN or in FINISH: next cycle busy=0, done=0, hi=lo=0.

Test Plan:
1. MULTU op_a=32'hFFFFFFFF, op_b=32'hFFFFFFFF → after 33 edges done=1 for one cycle, hi=32'hFFFFFFFE, lo=32'h00000001; busy high for exactly 33 cycles.
2. MULT op_a=-3 (32'hFFFFFFFD), op_b=7 → hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. Then MULT 0x80000000 x 0x80000000 → hi=32'h40000000, lo=0.
3. DIV op_a=-7, op_b=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/-1 → lo=32'h80000000, hi=0.
4. DIVU op_a=32'h12345678, op_b=0 → lo=32'hFFFFFFFF, hi=32'h12345678, done pulses at the normal time.
5. MTHI 32'hDEADBEEF then MTLO 32'hCAFEF00D on consecutive cycles → hi/lo updated the edge after each; busy and done stay 0. Then start MULTU 2x3 and, while busy, assert start with MTLO 5 (ignored) → lo=6, hi=0 at done.
6. Start MULT 5x5, assert reset at RUN cycle 10 for one cycle → hi=lo=0, busy=0, no done pulse. Then start DIVU 9/3 on the done cycle of a prior op (back-to-back) → lo=3, hi=0.
